alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 21 ++
 rtl/alu_seq.sv | 187 ++++++++++++++++++
 tb/tb_alu_seq.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for alu_seq: operands and opcode in,
// registered result, flags and illegal-opcode indication out.
interface alu_seq_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] r2;
  logic [7:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] rout;
  logic [4:0]       flags;
  logic             illegal;

  modport master (output in_valid, r1, r2, opcode, out_ready,
                  input  in_ready, out_valid, rout, flags, illegal);
  modport slave  (input  in_valid, r1, r2, opcode, out_ready,
                  output in_ready, out_valid, rout, flags, illegal);
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake; flags are {C, L, F, Z, N}.
// Define ALU_MULT_EN to add the iterative shift-add multiplier (opcode 0x0E).
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = 5
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_SUBC = 8'h0A;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_LSH  = 8'h84;
  localparam logic [7:0] OP_ASHU = 8'h86;
`ifdef ALU_MULT_EN
  localparam logic [7:0] OP_MUL  = 8'h0E;
  typedef enum logic [1:0] {IDLE, MUL, HOLD} stateT;
`else
  typedef enum logic {IDLE, HOLD} stateT;
`endif

  stateT            state, nextState, acceptState;
  logic [WIDTH-1:0] routReg, resRout, res;
  logic [4:0]       flagsReg, resFlags;
  logic             illegalReg, resIllegal;
  logic             accept, isMul, less, c, f, upd, keepA;
  logic [WIDTH:0]   sum, diff, cinExt;
  logic signed [SHW-1:0] amt;
  int               mag;

  // A held result that is draining this edge frees the block for a new request.
  assign bus.in_ready  = (state == IDLE) || (state == HOLD && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == HOLD);
  assign bus.rout      = routReg;
  assign bus.flags     = flagsReg;
  assign bus.illegal   = illegalReg;

  always_comb begin
    sum        = '0;
    diff       = '0;
    res        = '0;
    c          = 1'b0;
    f          = 1'b0;
    upd        = 1'b1;
    keepA      = 1'b0;
    isMul      = 1'b0;
    resIllegal = 1'b0;
    amt        = bus.r2[SHW-1:0];
    mag        = amt[SHW-1] ? -int'(amt) : int'(amt);
    less       = bus.r1 < bus.r2;
    cinExt     = '0;
    cinExt[0]  = flagsReg[4] && (bus.opcode == OP_ADDC || bus.opcode == OP_SUBC);
    case (bus.opcode)
      OP_ADD, OP_ADDU, OP_ADDC: begin
        sum = {1'b0, bus.r1} + {1'b0, bus.r2} + cinExt;
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        f   = (bus.opcode != OP_ADDU) && (bus.r1[WIDTH-1] == bus.r2[WIDTH-1]) &&
              (sum[WIDTH-1] != bus.r1[WIDTH-1]);
      end
      OP_SUB, OP_SUBC, OP_CMP: begin
        diff  = {1'b0, bus.r1} - {1'b0, bus.r2} - cinExt;
        res   = diff[WIDTH-1:0];
        c     = diff[WIDTH];
        f     = (bus.r1[WIDTH-1] != bus.r2[WIDTH-1]) && (diff[WIDTH-1] != bus.r1[WIDTH-1]);
        keepA = (bus.opcode == OP_CMP);
      end
      OP_AND: res = bus.r1 & bus.r2;
      OP_OR:  res = bus.r1 | bus.r2;
      OP_XOR: res = bus.r1 ^ bus.r2;
      OP_LSH, OP_ASHU: begin
        if (mag >= WIDTH)
          res = (bus.opcode == OP_ASHU && amt[SHW-1] && bus.r1[WIDTH-1]) ? '1 : '0;
        else if (!amt[SHW-1])
          res = bus.r1 << mag;
        else if (bus.opcode == OP_ASHU)
          res = $signed(bus.r1) >>> mag;
        else
          res = bus.r1 >> mag;
      end
`ifdef ALU_MULT_EN
      OP_MUL: begin
        isMul = 1'b1;
        upd   = 1'b0;
      end
`endif
      OP_NOP: upd = 1'b0;
      default: begin
        upd        = 1'b0;
        resIllegal = 1'b1;
      end
    endcase
    resRout  = keepA ? bus.r1 : res;
    resFlags = upd ? {c, less, f, res == '0, res[WIDTH-1]} : flagsReg;
  end

`ifdef ALU_MULT_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, mcand, nextAcc;
  logic [WIDTH-1:0]   mplier;
  logic               mulLess, mulDone;

  assign nextAcc = acc + (mplier[0] ? mcand : '0);
  assign mulDone = (state == MUL) && (cnt == LAST);

  // One multiplier bit per cycle: add the shifted multiplicand when the bit is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      mulLess <= 1'b0;
    end else if (accept && isMul) begin
      cnt     <= '0;
      acc     <= '0;
      mcand   <= {{WIDTH{1'b0}}, bus.r1};
      mplier  <= bus.r2;
      mulLess <= less;
    end else if (state == MUL) begin
      cnt    <= mulDone ? '0 : cnt + CW'(1);
      acc    <= nextAcc;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
`endif

  always_comb begin
    nextState = state;
`ifdef ALU_MULT_EN
    acceptState = isMul ? MUL : HOLD;
`else
    acceptState = HOLD;
`endif
    case (state)
      IDLE: if (accept) nextState = acceptState;
      HOLD: begin
        if (accept)             nextState = acceptState;
        else if (bus.out_ready) nextState = IDLE;
      end
`ifdef ALU_MULT_EN
      MUL:  if (mulDone) nextState = HOLD;
`endif
      default: nextState = IDLE;
    endcase
  end

  // Result registers only change on a load, so they stay put under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      routReg    <= '0;
      flagsReg   <= '0;
      illegalReg <= 1'b0;
    end else begin
      state <= nextState;
      if (accept && !isMul) begin
        routReg    <= resRout;
        flagsReg   <= resFlags;
        illegalReg <= resIllegal;
      end
`ifdef ALU_MULT_EN
      else if (mulDone) begin
        routReg    <= nextAcc[WIDTH-1:0];
        flagsReg   <= {|nextAcc[2*WIDTH-1:WIDTH], mulLess, 1'b0,
                       nextAcc[WIDTH-1:0] == '0, nextAcc[WIDTH-1]};
        illegalReg <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: integer reference model, directed corner cases,
// randomized operations with random backpressure.
module tb_alu_seq;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] rout;
    logic [4:0]  flags;
    logic        illegal;
  } expT;

  logic clk = 1'b0;
  logic rst_n;
  int   testsRun = 0;
  int   testsFailed = 0;
  int   readyMode = 1;
  int   lastWait = 0;
  logic [4:0] modelFlags = '0;
  expT  sb[$];
  logic [7:0] legalOps [13] = '{8'h05, 8'h06, 8'h07, 8'h0E, 8'h09, 8'h0A, 8'h0B,
                                8'h01, 8'h02, 8'h03, 8'h84, 8'h86, 8'h00};

  alu_seq_if #(.WIDTH(16)) aluBus ();
  alu_seq #(.WIDTH(16), .SHW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(aluBus));

  always #5 clk = ~clk;

  // Reference model in plain integer arithmetic on 16-bit operands.
  function automatic expT modelOp(input logic [7:0] op, input logic [15:0] a,
                                  input logic [15:0] b, input logic [4:0] prevFlags);
    longint m, ua, ub, sa, sb2, cin, r, sr;
    int     amt;
    bit     c, f, upd, keepA, ill;
    expT    e;
    m = 65536; ua = longint'(a); ub = longint'(b);
    sa = a[15] ? ua - m : ua; sb2 = b[15] ? ub - m : ub;
    cin = longint'(prevFlags[4]); r = 0; sr = 0;
    c = 0; f = 0; upd = 1; keepA = 0; ill = 0;
    case (op)
      8'h05, 8'h06, 8'h07: begin
        if (op != 8'h07) cin = 0;
        r = ua + ub + cin; sr = sa + sb2 + cin;
        c = r >= m; f = (op != 8'h06) && (sr > 32767 || sr < -32768);
        r = r % m;
      end
      8'h09, 8'h0A, 8'h0B: begin
        if (op != 8'h0A) cin = 0;
        r = ua - ub - cin; sr = sa - sb2 - cin;
        c = r < 0; f = sr > 32767 || sr < -32768;
        r = (r + m) % m; keepA = (op == 8'h0B);
      end
      8'h01: r = longint'(a & b);
      8'h02: r = longint'(a | b);
      8'h03: r = longint'(a ^ b);
      8'h84, 8'h86: begin
        amt = int'(b[4:0]);
        if (amt >= 16) amt -= 32;
        if (amt >= 0)        r = (amt >= 16) ? 0 : (ua << amt) % m;
        else if (-amt >= 16) r = (op == 8'h86 && sa < 0) ? m - 1 : 0;
        else if (op == 8'h86) r = ((sa >>> (-amt)) + m) % m;
        else                 r = ua >> (-amt);
      end
`ifdef ALU_MULT_EN
      8'h0E: begin
        r = ua * ub; c = r >= m; r = r % m;
      end
`endif
      8'h00: upd = 0;
      default: begin upd = 0; ill = 1; end
    endcase
    e.op = op;
    e.rout = keepA ? a : r[15:0];
    e.illegal = ill;
    e.flags = upd ? {c, ua < ub, f, r == 0, r[15]} : prevFlags;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Holds the request until accepted; the expected result is queued at acceptance.
  task automatic applyStimulus(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    bit  done = 0;
    expT e;
    lastWait = 0;
    aluBus.in_valid = 1'b1; aluBus.opcode = op; aluBus.r1 = a; aluBus.r2 = b;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (aluBus.in_ready) begin
        e = modelOp(op, a, b, modelFlags);
        modelFlags = e.flags;
        sb.push_back(e);
        done = 1;
      end else lastWait++;
      @(posedge clk); #1;
    end
    aluBus.in_valid = 1'b0;
    aluBus.r1 = 16'($urandom); aluBus.r2 = 16'($urandom); aluBus.opcode = 8'($urandom);
    if (!done) begin
      testsRun++; testsFailed++;
      $display("[TB] FAIL accept_timeout: op 0x%02h never accepted", op);
    end
  endtask

  task automatic runDirected(input string name, input logic [7:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] expRout,
                             input logic [4:0] expFlags, input logic expIllegal);
    applyStimulus(op, a, b);
    @(negedge clk);
    checkOutput({name, "_valid"}, 32'(aluBus.out_valid), 32'd1);
    checkOutput({name, "_rout"}, 32'(aluBus.rout), 32'(expRout));
    checkOutput({name, "_flags"}, 32'(aluBus.flags), 32'(expFlags));
    checkOutput({name, "_illegal"}, 32'(aluBus.illegal), 32'(expIllegal));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit ok = 0;
    readyMode = 1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !aluBus.out_valid) ok = 1;
    end
    if (!ok) begin
      testsRun++; testsFailed++;
      $display("[TB] FAIL drain_timeout: %0d results still pending", sb.size());
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Consumer side: out_ready is policy-driven, updated shortly after each edge.
  initial begin : backpressure
    aluBus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (readyMode)
        0: aluBus.out_ready = 1'b0;
        1: aluBus.out_ready = 1'b1;
        default: aluBus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Every handshaken result is compared with the oldest queued expectation.
  initial begin : monitor
    expT e;
    forever begin
      @(negedge clk);
      if (rst_n && aluBus.out_valid && aluBus.out_ready) begin
        if (sb.size() == 0) begin
          testsRun++; testsFailed++;
          $display("[TB] FAIL unexpected_result: rout 0x%0h, expected no result", aluBus.rout);
        end else begin
          e = sb.pop_front();
          checkOutput($sformatf("rout_op%02h", e.op), 32'(aluBus.rout), 32'(e.rout));
          checkOutput($sformatf("flags_op%02h", e.op), 32'(aluBus.flags), 32'(e.flags));
          checkOutput($sformatf("illegal_op%02h", e.op), 32'(aluBus.illegal), 32'(e.illegal));
        end
      end
    end
  end

  initial begin : main
    logic [7:0] op;
    rst_n = 1'b1;
    aluBus.in_valid = 1'b0; aluBus.r1 = '0; aluBus.r2 = '0; aluBus.opcode = '0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_valid", 32'(aluBus.out_valid), 32'd0);
    checkOutput("reset_rout", 32'(aluBus.rout), 32'd0);
    checkOutput("reset_flags", 32'(aluBus.flags), 32'd0);
    checkOutput("reset_illegal", 32'(aluBus.illegal), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    runDirected("add_ovf", 8'h05, 16'h7FFF, 16'h0001, 16'h8000, 5'b00101, 1'b0);
    runDirected("sub_neg", 8'h09, 16'h0003, 16'h0005, 16'hFFFE, 5'b11001, 1'b0);
    runDirected("subc_borrow", 8'h0A, 16'h0000, 16'h0000, 16'hFFFF, 5'b10001, 1'b0);
    runDirected("ashu_right4", 8'h86, 16'h8000, 16'hFFFC, 16'hF800, 5'b01001, 1'b0);
    runDirected("lsh_right4", 8'h84, 16'h8000, 16'hFFFC, 16'h0800, 5'b01000, 1'b0);
    runDirected("lsh_16", 8'h84, 16'h8000, 16'h0010, 16'h0000, 5'b00010, 1'b0);
`ifdef ALU_MULT_EN
    applyStimulus(8'h0E, 16'h0100, 16'h0100);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checkOutput("mul_busy_ready", 32'(aluBus.in_ready), 32'd0);
      checkOutput("mul_busy_valid", 32'(aluBus.out_valid), 32'd0);
    end
    @(negedge clk);
    checkOutput("mul_valid", 32'(aluBus.out_valid), 32'd1);
    checkOutput("mul_rout", 32'(aluBus.rout), 32'h0000);
    checkOutput("mul_flags", 32'(aluBus.flags), 32'(5'b10010));
    @(posedge clk); #1;
`else
    runDirected("mul_undecoded", 8'h0E, 16'h0100, 16'h0100, 16'h0000, 5'b00010, 1'b1);
`endif

    // Backpressure: result must stay frozen, then drain and reload on one edge.
    drain();
    readyMode = 0;
    @(posedge clk); #3;
    applyStimulus(8'h05, 16'h7FFF, 16'h0001);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall_valid", 32'(aluBus.out_valid), 32'd1);
      checkOutput("stall_in_ready", 32'(aluBus.in_ready), 32'd0);
      checkOutput("stall_rout", 32'(aluBus.rout), 32'h8000);
      checkOutput("stall_flags", 32'(aluBus.flags), 32'(5'b00101));
    end
    @(posedge clk); #1;
    readyMode = 1;
    runDirected("reload_xor", 8'h03, 16'h00FF, 16'h0F0F, 16'h0FF0, 5'b01000, 1'b0);
    checkOutput("reload_same_edge", 32'(lastWait), 32'd0);

    // Reset in the middle of an operation discards it asynchronously.
    drain();
    runDirected("pre_reset_add", 8'h05, 16'h7FFF, 16'h0001, 16'h8000, 5'b00101, 1'b0);
    readyMode = 0;
    @(posedge clk); #3;
`ifdef ALU_MULT_EN
    applyStimulus(8'h0E, 16'h1234, 16'h0005);
`else
    applyStimulus(8'h05, 16'h7FFF, 16'h0001);
`endif
    repeat (3) @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    checkOutput("midop_reset_valid", 32'(aluBus.out_valid), 32'd0);
    checkOutput("midop_reset_flags", 32'(aluBus.flags), 32'd0);
    checkOutput("midop_reset_rout", 32'(aluBus.rout), 32'd0);
    sb.delete();
    modelFlags = '0;
    @(negedge clk); rst_n = 1'b1; readyMode = 1;
    @(posedge clk); #1;
    runDirected("illegal_ff", 8'hFF, 16'h1234, 16'h5678, 16'h0000, 5'b00000, 1'b1);

    // Randomized traffic with random idle gaps and random consumer stalls.
    readyMode = 2;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 15) == 0) op = 8'($urandom);
      else op = legalOps[$urandom_range(0, 12)];
      applyStimulus(op, pickOperand(), pickOperand());
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
